// File: rtl/acq_sched_pkg.sv
// Shared types and constants for the acquisition converter scheduler.
// The scheduler also uses the optional macro ACQ_SCHED_OVERRUN_CNT_EN.
package acq_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_VIB_REQ = 2'd1,
    ST_ADC_REQ = 2'd2
  } sched_state_e;

  localparam logic CONV_SRC_ADC = 1'b0;
  localparam logic CONV_SRC_VIB = 1'b1;

  localparam int CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (&val) ? val : val + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit saturating event counter with synchronous clear.
module sat_cnt16
  import acq_sched_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= sat_inc(r_cnt);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/acq_conv_scheduler.sv
// Arbitrates the shared converter between the vibration channel and the ADC scan.
// Define ACQ_SCHED_OVERRUN_CNT_EN to build the dropped-request counters.
module acq_conv_scheduler
  import acq_sched_pkg::*;
#(
  parameter int ADC_CH_NUM   = 8,
  parameter int VIB_CH       = 15,
  parameter int CONV_TIMEOUT = 400
) (
  input  logic             sys_clk_i,
  input  logic             rst_i,
  input  logic             time_period_0_10ms_i,
  input  logic             time_period_25ms_pluse_i,
  input  logic             adc_acq_start_pluse_i,
  input  logic             vibration_acq_start_pluse_i,
  output logic             conv_req_o,
  output logic [3:0]       conv_ch_o,
  output logic             conv_src_o,
  input  logic             conv_done_i,
  output logic             adc_scan_done_pluse_o,
  output logic [CNT_W-1:0] frame_seq_o,
  output logic             busy_o,
  output logic             timeout_err_o,
  output logic [CNT_W-1:0] vib_overrun_cnt_o,
  output logic [CNT_W-1:0] adc_overrun_cnt_o
);

  localparam logic [3:0]       LP_SCAN_LEN  = 4'(ADC_CH_NUM);
  localparam logic [3:0]       LP_SCAN_LAST = 4'(ADC_CH_NUM - 1);
  localparam logic [3:0]       LP_VIB_CH    = 4'(VIB_CH);
  localparam logic [CNT_W-1:0] LP_TO_LAST   = CNT_W'(CONV_TIMEOUT - 1);

  sched_state_e     r_state, w_state_nxt;
  logic             r_vib_pend, w_vib_pend_nxt;
  logic             r_adc_pend, w_adc_pend_nxt;
  logic             r_scan_act, w_scan_act_nxt;
  logic [3:0]       r_scan_idx, w_scan_idx_nxt;
  logic [CNT_W-1:0] r_to_cnt, w_to_cnt_nxt;

  logic             w_vib_take;
  logic             w_adc_take;
  logic             w_timeout;
  logic             w_scan_done;

  logic             r_conv_req;
  logic [3:0]       r_conv_ch;
  logic             r_conv_src;
  logic             r_scan_done;
  logic [CNT_W-1:0] r_frame_seq;
  logic             r_busy;
  logic             r_timeout_err;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_state_nxt    = r_state;
    w_scan_act_nxt = r_scan_act;
    w_scan_idx_nxt = r_scan_idx;
    w_to_cnt_nxt   = '0;
    w_vib_take     = 1'b0;
    w_adc_take     = 1'b0;
    w_timeout      = 1'b0;
    w_scan_done    = 1'b0;
    w_vib_pend_nxt = r_vib_pend;
    w_adc_pend_nxt = r_adc_pend;

    unique case (r_state)
      ST_IDLE: begin
        if (!time_period_0_10ms_i) begin
          if (r_vib_pend) begin
            w_state_nxt = ST_VIB_REQ;
            w_vib_take  = 1'b1;
          end else if (r_scan_act && (r_scan_idx < LP_SCAN_LEN)) begin
            w_state_nxt = ST_ADC_REQ;
          end else if (r_adc_pend) begin
            w_adc_take     = 1'b1;
            w_scan_act_nxt = 1'b1;
            w_scan_idx_nxt = '0;
            w_state_nxt    = ST_ADC_REQ;
          end
        end
      end
      ST_VIB_REQ, ST_ADC_REQ: begin
        // A timeout is handled exactly like a done so the scan keeps moving.
        w_timeout = !conv_done_i && (r_to_cnt == LP_TO_LAST);
        if (conv_done_i || w_timeout) begin
          w_state_nxt = ST_IDLE;
          if (r_state == ST_ADC_REQ) begin
            w_scan_idx_nxt = r_scan_idx + 4'd1;
            if (r_scan_idx == LP_SCAN_LAST) begin
              w_scan_act_nxt = 1'b0;
              w_scan_done    = 1'b1;
            end
          end
        end else begin
          w_to_cnt_nxt = r_to_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // A pulse landing on the cycle its flag is consumed re-arms the flag.
    if (time_period_0_10ms_i) begin
      w_vib_pend_nxt = 1'b0;
      w_adc_pend_nxt = 1'b0;
      w_scan_act_nxt = 1'b0;
    end else begin
      w_vib_pend_nxt = (r_vib_pend & ~w_vib_take) | vibration_acq_start_pluse_i;
      w_adc_pend_nxt = (r_adc_pend & ~w_adc_take) |
                       (adc_acq_start_pluse_i & ~r_scan_act & ~(r_adc_pend & ~w_adc_take));
    end
  end

  always_ff @(posedge sys_clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      r_state       <= ST_IDLE;
      r_vib_pend    <= 1'b0;
      r_adc_pend    <= 1'b0;
      r_scan_act    <= 1'b0;
      r_scan_idx    <= '0;
      r_to_cnt      <= '0;
      r_conv_req    <= 1'b0;
      r_conv_ch     <= '0;
      r_conv_src    <= CONV_SRC_ADC;
      r_scan_done   <= 1'b0;
      r_frame_seq   <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_vib_pend  <= w_vib_pend_nxt;
      r_adc_pend  <= w_adc_pend_nxt;
      r_scan_act  <= w_scan_act_nxt;
      r_scan_idx  <= w_scan_idx_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
      r_conv_req  <= (w_state_nxt != ST_IDLE);
      r_conv_src  <= (w_state_nxt == ST_VIB_REQ) ? CONV_SRC_VIB : CONV_SRC_ADC;
      r_scan_done <= w_scan_done;
      r_busy      <= (w_state_nxt != ST_IDLE) | w_vib_pend_nxt | w_adc_pend_nxt | w_scan_act_nxt;
      if (w_state_nxt == ST_VIB_REQ) begin
        r_conv_ch <= LP_VIB_CH;
      end else if (w_state_nxt == ST_ADC_REQ) begin
        r_conv_ch <= w_scan_idx_nxt;
      end
      if (time_period_25ms_pluse_i) begin
        r_frame_seq <= r_frame_seq + CNT_W'(1);
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign conv_req_o            = r_conv_req;
  assign conv_ch_o             = r_conv_ch;
  assign conv_src_o            = r_conv_src;
  assign adc_scan_done_pluse_o = r_scan_done;
  assign frame_seq_o           = r_frame_seq;
  assign busy_o                = r_busy;
  assign timeout_err_o         = r_timeout_err;

`ifdef ACQ_SCHED_OVERRUN_CNT_EN
  logic w_vib_ovr;
  logic w_adc_ovr;

  assign w_vib_ovr = vibration_acq_start_pluse_i & ~time_period_0_10ms_i &
                     r_vib_pend & ~w_vib_take;
  assign w_adc_ovr = adc_acq_start_pluse_i & ~time_period_0_10ms_i &
                     (r_scan_act | (r_adc_pend & ~w_adc_take));

  sat_cnt16 u_vib_ovr_cnt (
    .i_clk (sys_clk_i),
    .i_clr (rst_i),
    .i_inc (w_vib_ovr),
    .o_cnt (vib_overrun_cnt_o)
  );

  sat_cnt16 u_adc_ovr_cnt (
    .i_clk (sys_clk_i),
    .i_clr (rst_i),
    .i_inc (w_adc_ovr),
    .o_cnt (adc_overrun_cnt_o)
  );
`else
  assign vib_overrun_cnt_o = '0;
  assign adc_overrun_cnt_o = '0;
`endif

endmodule

// File: tb/tb_acq_conv_scheduler.sv
// Directed bench for acq_conv_scheduler: scan order, vibration insertion, overrun,
// timeout, hold-off, frame count and mid-request reset.
module tb_acq_conv_scheduler;

  localparam int N_CH   = 8;
  localparam int VIB    = 15;
  localparam int TO     = 400;
  localparam int VIBLOG = 32'h1F;  // {src=1, ch=15}

`ifdef ACQ_SCHED_OVERRUN_CNT_EN
  localparam int EXP_VIB_OVR = 1;
`else
  localparam int EXP_VIB_OVR = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold = 1'b0;
  logic        frame_p = 1'b0;
  logic        adc_p = 1'b0;
  logic        vib_p = 1'b0;
  logic        done;
  logic        conv_req_o;
  logic [3:0]  conv_ch_o;
  logic        conv_src_o;
  logic        scan_done;
  logic [15:0] frame_seq;
  logic        busy_o;
  logic        timeout_err;
  logic [15:0] vib_ovr;
  logic [15:0] adc_ovr;

  always #5 clk = ~clk;

  acq_conv_scheduler #(
    .ADC_CH_NUM   (N_CH),
    .VIB_CH       (VIB),
    .CONV_TIMEOUT (TO)
  ) dut (
    .sys_clk_i                   (clk),
    .rst_i                       (rst),
    .time_period_0_10ms_i        (hold),
    .time_period_25ms_pluse_i    (frame_p),
    .adc_acq_start_pluse_i       (adc_p),
    .vibration_acq_start_pluse_i (vib_p),
    .conv_req_o                  (conv_req_o),
    .conv_ch_o                   (conv_ch_o),
    .conv_src_o                  (conv_src_o),
    .conv_done_i                 (done),
    .adc_scan_done_pluse_o       (scan_done),
    .frame_seq_o                 (frame_seq),
    .busy_o                      (busy_o),
    .timeout_err_o               (timeout_err),
    .vib_overrun_cnt_o           (vib_ovr),
    .adc_overrun_cnt_o           (adc_ovr)
  );

  int       n_tests = 0;
  int       n_fail  = 0;
  bit       resp_en = 1'b0;
  logic [4:0] req_log[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    return (i < req_log.size()) ? 32'(req_log[i]) : 32'hDEAD;
  endfunction

  // Converter model: answers done on the 5th sampled cycle of each request.
  initial begin : responder
    int cnt;
    cnt  = 0;
    done = 1'b0;
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (rst || !resp_en || !conv_req_o) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt == 5) done = 1'b1;
      end
    end
  end

  // Records {src, ch} at the start of every request.
  initial begin : monitor
    logic prev;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (conv_req_o && !prev) req_log.push_back({conv_src_o, conv_ch_o});
      prev = conv_req_o;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic v, input logic a);
    vib_p = v;
    adc_p = a;
    cyc(1);
    vib_p = 1'b0;
    adc_p = 1'b0;
  endtask

  task automatic wait_req(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (conv_req_o) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_scan_done(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc(1);
      if (scan_done) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy_o && !conv_req_o) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_req"},     32'(conv_req_o),  32'd0);
    check({pfx, "_ch"},      32'(conv_ch_o),   32'd0);
    check({pfx, "_src"},     32'(conv_src_o),  32'd0);
    check({pfx, "_sdone"},   32'(scan_done),   32'd0);
    check({pfx, "_frame"},   32'(frame_seq),   32'd0);
    check({pfx, "_busy"},    32'(busy_o),      32'd0);
    check({pfx, "_toerr"},   32'(timeout_err), 32'd0);
    check({pfx, "_vib_ovr"}, 32'(vib_ovr),     32'd0);
    check({pfx, "_adc_ovr"}, 32'(adc_ovr),     32'd0);
  endtask

  initial begin : stim
    int  hi;
    int  extra;
    bit  any_req;
    bit  any_busy;
    bit  found;
    int  exp_seq2[9];

    // Reset state
    cyc(3);
    check_all_zero("rst");
    rst = 1'b0;
    cyc(2);

    // Full scan of 8 channels, 2-cycle request latency
    resp_en = 1'b1;
    req_log.delete();
    pulse(1'b0, 1'b1);
    check("t1_req_k", 32'(conv_req_o), 32'd0);
    check("t1_busy_k", 32'(busy_o), 32'd1);
    cyc(1);
    check("t1_req_k1", 32'(conv_req_o), 32'd1);
    check("t1_ch0", 32'(conv_ch_o), 32'd0);
    check("t1_src0", 32'(conv_src_o), 32'd0);
    wait_scan_done("t1_scan_done", 200);
    cyc(1);
    check("t1_done_width", 32'(scan_done), 32'd0);
    extra = 0;
    repeat (20) begin
      cyc(1);
      extra += int'(scan_done);
    end
    check("t1_done_once", 32'(extra), 32'd0);
    check("t1_log_size", 32'(req_log.size()), 32'd8);
    for (int i = 0; i < N_CH; i++) check($sformatf("t1_seq%0d", i), log_at(i), 32'(i));
    check("t1_busy_end", 32'(busy_o), 32'd0);

    // Vibration inserted after channel 3, scan resumes at 4
    req_log.delete();
    pulse(1'b0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (conv_req_o && conv_ch_o == 4'd3) begin
        found = 1'b1;
        break;
      end
      cyc(1);
    end
    check("t2_saw_ch3", 32'(found), 32'd1);
    pulse(1'b1, 1'b0);
    wait_scan_done("t2_scan_done", 300);
    exp_seq2 = '{0, 1, 2, 3, VIBLOG, 4, 5, 6, 7};
    check("t2_log_size", 32'(req_log.size()), 32'd9);
    for (int i = 0; i < 9; i++) check($sformatf("t2_seq%0d", i), log_at(i), 32'(exp_seq2[i]));

    // Vibration overrun while the converter is silent
    wait_idle("t3_idle", 50);
    resp_en = 1'b0;
    req_log.delete();
    pulse(1'b1, 1'b0);
    wait_req("t3_req", 10);
    cyc(2);
    pulse(1'b1, 1'b0);
    cyc(2);
    pulse(1'b1, 1'b0);
    cyc(1);
    check("t3_vib_ovr", 32'(vib_ovr), 32'(EXP_VIB_OVR));
    check("t3_req_held", 32'(conv_req_o), 32'd1);
    check("t3_src_vib", 32'(conv_src_o), 32'd1);
    check("t3_ch_vib", 32'(conv_ch_o), 32'(VIB));
    check("t3_log_one", 32'(req_log.size()), 32'd1);
    resp_en = 1'b1;
    cyc(40);
    check("t3_log_two", 32'(req_log.size()), 32'd2);
    check("t3_second_vib", log_at(1), 32'(VIBLOG));
    check("t3_idle_end", 32'(busy_o), 32'd0);

    // Conversion timeout advances the scan
    resp_en = 1'b0;
    req_log.delete();
    pulse(1'b0, 1'b1);
    wait_req("t4_req", 10);
    hi = 0;
    while (conv_req_o && hi < 1000) begin
      hi++;
      cyc(1);
    end
    resp_en = 1'b1;
    check("t4_req_cycles", 32'(hi), 32'(TO));
    check("t4_toerr", 32'(timeout_err), 32'd1);
    wait_scan_done("t4_scan_done", 300);
    check("t4_log_size", 32'(req_log.size()), 32'd8);
    check("t4_seq1", log_at(1), 32'd1);
    check("t4_seq7", log_at(7), 32'd7);
    check("t4_toerr_sticky", 32'(timeout_err), 32'd1);

    // Hold-off discards ADC pulses
    wait_idle("t5_idle", 50);
    req_log.delete();
    hold = 1'b1;
    cyc(1);
    any_req  = 1'b0;
    any_busy = 1'b0;
    repeat (10) begin
      pulse(1'b0, 1'b1);
      any_req  |= conv_req_o;
      any_busy |= busy_o;
      cyc(1);
    end
    check("t5_no_req", 32'(any_req), 32'd0);
    check("t5_no_busy", 32'(any_busy), 32'd0);
    check("t5_adc_ovr", 32'(adc_ovr), 32'd0);
    check("t5_vib_ovr", 32'(vib_ovr), 32'(EXP_VIB_OVR));
    hold = 1'b0;
    cyc(6);
    check("t5_after_req", 32'(conv_req_o), 32'd0);
    check("t5_after_log", 32'(req_log.size()), 32'd0);
    check("t5_after_busy", 32'(busy_o), 32'd0);

    // Frame count, then reset in the middle of a request
    repeat (3) begin
      frame_p = 1'b1;
      cyc(1);
      frame_p = 1'b0;
      cyc(1);
    end
    check("t6_frame", 32'(frame_seq), 32'd3);
    resp_en = 1'b0;
    pulse(1'b1, 1'b0);
    wait_req("t6_req", 10);
    cyc(3);
    check("t6_pre_src", 32'(conv_src_o), 32'd1);
    rst = 1'b1;
    cyc(1);
    check_all_zero("t6_rst");
    rst = 1'b0;
    cyc(2);

    // Simultaneous vibration and ADC pulses are both served, vibration first
    resp_en = 1'b1;
    req_log.delete();
    pulse(1'b1, 1'b1);
    wait_scan_done("t7_scan_done", 300);
    check("t7_log_size", 32'(req_log.size()), 32'd9);
    check("t7_first_vib", log_at(0), 32'(VIBLOG));
    check("t7_then_ch0", log_at(1), 32'd0);
    check("t7_last_ch7", log_at(8), 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/acq_conv_scheduler.md
# acq_conv_scheduler

Schedules the shared acquisition converter port between the vibration channel and the scanned ADC channels. Consumes the start pulses and the 0–10 ms reset window from the acquisition time base, and issues one conversion request at a time over a req/done handshake. The vibration channel has priority. The block sits between the time base and the converter front-end driver.

## Interface
- `ADC_CH_NUM`, 8: ADC channels scanned per ADC start pulse (1–15).
- `VIB_CH`, 15: channel code driven for vibration conversions.
- `CONV_TIMEOUT`, 400: cycles `conv_req_o` may stay high without `conv_done_i` (≥2, <65536).
- `sys_clk_i` in 1: 100 MHz system clock; the only clock.
- `rst_i` in 1: synchronous, active-high reset.
- `time_period_0_10ms_i` in 1: reset window from the time base; high = hold off.
- `time_period_25ms_pluse_i` in 1: frame boundary pulse.
- `adc_acq_start_pluse_i` in 1: ADC scan start pulse, 1 cycle.
- `vibration_acq_start_pluse_i` in 1: vibration conversion pulse, 1 cycle.
- `conv_req_o` out 1: conversion request, level.
- `conv_ch_o` out 4: channel code; stable while `conv_req_o` is high.
- `conv_src_o` out 1: 1 = vibration, 0 = ADC scan.
- `conv_done_i` in 1: converter completion, 1 cycle.
- `adc_scan_done_pluse_o` out 1: last ADC channel of a scan finished.
- `frame_seq_o` out 16: count of 25 ms frames; wraps.
- `busy_o` out 1: state is not IDLE, or a request is pending.
- `timeout_err_o` out 1: sticky; a conversion timed out.
- `vib_overrun_cnt_o` out 16: dropped vibration requests.
- `adc_overrun_cnt_o` out 16: dropped ADC scan requests.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset also clears both pending flags, `scan_idx` and the timeout counter.
- **Pending flags**
  - A vibration pulse sets `vib_pend`.
  - An ADC pulse sets `adc_pend`, unless a scan is already pending or active (see overrun rule below).
- **FSM states**
  - IDLE:
    - if `vib_pend`, go to VIB_REQ and clear `vib_pend`;
    - else if a scan is active (`scan_idx` < `ADC_CH_NUM`, scan flag set), go to ADC_REQ;
    - else if `adc_pend`, clear it, set the scan flag with `scan_idx` = 0, and go to ADC_REQ.
  - VIB_REQ: `conv_req_o` = 1, `conv_ch_o` = `VIB_CH`, `conv_src_o` = 1.
  - ADC_REQ: `conv_req_o` = 1, `conv_ch_o` = `scan_idx`, `conv_src_o` = 0.
  - In either REQ state, `conv_done_i` or a timeout returns the FSM to IDLE and drops `conv_req_o`.
  - In ADC_REQ, completion also increments `scan_idx`. If `scan_idx` was `ADC_CH_NUM`-1, it clears the scan flag and pulses `adc_scan_done_pluse_o`.
- **Priority:** vibration wins only at IDLE. A conversion is never preempted. A pending vibration is inserted between ADC channels, and the scan resumes at the next channel.
- **Overrun** (counters saturate at 0xFFFF):
  - vibration pulse while `vib_pend` is already set → `vib_overrun_cnt_o`+1;
  - ADC pulse while `adc_pend` or the scan flag is set → pulse dropped, `adc_overrun_cnt_o`+1.
- **Simultaneous events**
  - A pulse arriving in the same cycle its pending flag is consumed re-sets the flag. This is not an overrun.
  - A vibration pulse and an ADC pulse in the same cycle are both latched.
- **Timeout:** the counter runs in the REQ states. When it reaches `CONV_TIMEOUT`-1 without done, the conversion is treated as complete and `timeout_err_o` is set until reset.
- `conv_done_i` outside the REQ states is ignored.
- **Hold-off:** while `time_period_0_10ms_i` is high, pulses are discarded and pending flags and the scan flag are cleared. An in-flight request completes normally; after that the FSM stays in IDLE.
- **Frames:** `time_period_25ms_pluse_i` increments `frame_seq_o`, and has no effect on scheduling.

## Timing
- Pulse at edge k → pending set at k → FSM leaves IDLE at k+1 → `conv_req_o` high after edge k+1. Latency is 2 cycles from the pulse cycle.
- `conv_done_i` sampled at edge d → `conv_req_o` low after d.
- There is a minimum of 1 IDLE cycle between consecutive requests.
- `adc_scan_done_pluse_o` is high for exactly the cycle after the final done.
- A synchronous reset mid-request drops `conv_req_o` on the next edge.

## Configuration
- `ACQ_SCHED_OVERRUN_CNT_EN` defined: overrun counters as specified above.
- Not defined: both counter outputs tie to 0 and the counter logic is removed. Dropping behaviour is unchanged.

## Structure
- Shared package `acq_sched_pkg`:
  - FSM state encodings (IDLE = 0, VIB_REQ = 1, ADC_REQ = 2);
  - `CONV_SRC_ADC` / `CONV_SRC_VIB` constants;
  - 16-bit counter width constant.
- One sub-module, `sat_cnt16`: a saturating increment counter with synchronous clear, instantiated twice for the overrun counters.

## Test plan
- `ADC_CH_NUM` = 8 with done returned 5 cycles after each req, one ADC pulse → channels 0..7 in order, `adc_scan_done_pluse_o` once, first `conv_req_o` 2 cycles after the pulse.
- Vibration pulse during ADC channel 3 → channel 3 completes, then `VIB_CH` = 15 with `conv_src_o` = 1, then the scan resumes at channel 4.
- Two vibration pulses before the converter answers (done held off) → `vib_overrun_cnt_o` = 1, and one vibration conversion is pending.
- `conv_done_i` never asserted, `CONV_TIMEOUT` = 400 → `conv_req_o` drops after 400 cycles, `timeout_err_o` = 1, and the scan advances.
- `time_period_0_10ms_i` high with 10 ADC pulses → no requests and no overrun increments, `busy_o` = 0.
- Three `time_period_25ms_pluse_i` pulses, then `rst_i` mid-request → `frame_seq_o` = 3, then every output is 0 one edge after reset.
